// File: rtl/wb_trace_pkg.sv
// Shared types for the write-back trace checker.
//   commit_t  : one retired register write (pc, destination register, data)
//   state_t   : checker control states
//   popcount  : number of set bits in a 32-bit vector (used for retire counting)
package wb_trace_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } commit_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/wb_trace_checker_fifo.sv
// Commit FIFO: up to LANES writes per cycle, one read per cycle.
// Valid lanes are packed contiguously in ascending lane order. A cycle's group
// is accepted whole or dropped whole; the fit check uses the post-pop count so
// a simultaneous pop frees a slot for the same cycle's pushes.
//   clk, resetn   : clock, async active-low reset
//   i_flush       : empty the FIFO (wins over push and pop)
//   i_push_en     : capture allowed this cycle
//   i_lane_vld    : per-lane qualifying write
//   i_lane_data   : per-lane commit record
//   i_pop         : consume the head entry
//   o_head        : head entry, read straight from the storage flops
//   o_empty       : FIFO holds no entries
//   o_overflow    : this cycle's group did not fit and was dropped
module wb_commit_fifo
   import wb_trace_pkg::*;
#(
   parameter int LANES = 2,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_flush,
   input  logic                  i_push_en,
   input  logic [LANES-1:0]      i_lane_vld,
   input  commit_t [LANES-1:0]   i_lane_data,
   input  logic                  i_pop,
   output commit_t               o_head,
   output logic                  o_empty,
   output logic                  o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   commit_t          r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;

   logic [AW-1:0]    w_idx [LANES];
   logic [CW-1:0]    w_acc;
   logic [CW-1:0]    w_n;
   logic [CW-1:0]    w_after_pop;
   logic [CW-1:0]    w_free;
   logic             w_pop;
   logic             w_fit;
   logic             w_push;

   // Slot offset of each lane = number of valid lanes below it (compaction).
   always_comb begin
      w_acc = {CW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         w_idx[i] = r_wr_ptr + w_acc[AW-1:0];
         w_acc    = w_acc + {{AW{1'b0}}, i_lane_vld[i]};
      end
      w_n = w_acc;
   end

   assign w_pop       = i_pop && (r_count != {CW{1'b0}});
   assign w_after_pop = r_count - {{AW{1'b0}}, w_pop};
   assign w_free      = CW'(DEPTH) - w_after_pop;
   assign w_fit       = (w_n <= w_free);
   assign w_push      = i_push_en && !i_flush && w_fit && (w_n != {CW{1'b0}});
   assign o_overflow  = i_push_en && !i_flush && !w_fit;
   assign o_head      = r_mem[r_rd_ptr];
   assign o_empty     = (r_count == {CW{1'b0}});

   // Storage write: each valid lane lands in its compacted slot.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (w_push && i_lane_vld[i]) begin
            r_mem[w_idx[i]] <= i_lane_data[i];
         end
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_ptr <= {AW{1'b0}};
         r_wr_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else if (i_flush) begin
         r_rd_ptr <= {AW{1'b0}};
         r_wr_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + w_n[AW-1:0];
            r_count  <= w_after_pop + w_n;
         end else begin
            r_count  <= w_after_pop;
         end
      end
   end

endmodule

// File: rtl/wb_trace_checker.sv
// Write-back trace checker: captures qualifying retired register writes from
// LANES write-back channels, serialises them through a commit FIFO and compares
// each against a golden trace entry delivered over a valid/ready port.
//   clk, resetn                  : clock, async active-low reset
//   enable                       : arms the checker (drop to return to IDLE)
//   wb_en/wb_rd/wb_wdata/wb_pc   : per-lane write-back tap (lane 0 oldest)
//   wb_retire                    : per-lane retire strobe for inst_cnt
//   ref_valid/ref_ready          : golden entry handshake
//   ref_pc/ref_wnum/ref_wdata    : golden entry
//   inst_cnt/cmp_cnt/err_cnt     : saturating counters
//   err, err_*, exp_*            : sticky first-mismatch capture
//   overflow                     : sticky commit FIFO overflow
//   done                         : END_PC golden entry consumed
module wb_trace_checker
   import wb_trace_pkg::*;
#(
   parameter int          LANES       = 2,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [31:0] SKIP_BASE   = 32'hbfc00380,
   parameter logic [31:0] SKIP_MASK   = 32'hfffffff8,
   parameter logic [31:0] END_PC      = 32'hbfc00100,
   parameter bit          STOP_ON_ERR = 1'b1,
   parameter int          CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic [LANES-1:0]      wb_en,
   input  logic [5*LANES-1:0]    wb_rd,
   input  logic [32*LANES-1:0]   wb_wdata,
   input  logic [32*LANES-1:0]   wb_pc,
   input  logic [LANES-1:0]      wb_retire,
   input  logic                  ref_valid,
   output logic                  ref_ready,
   input  logic [31:0]           ref_pc,
   input  logic [4:0]            ref_wnum,
   input  logic [31:0]           ref_wdata,
   output logic [CNT_W-1:0]      inst_cnt,
   output logic [CNT_W-1:0]      cmp_cnt,
   output logic [CNT_W-1:0]      err_cnt,
   output logic                  err,
   output logic [31:0]           err_pc,
   output logic [4:0]            err_wnum,
   output logic [31:0]           err_wdata,
   output logic [31:0]           exp_pc,
   output logic [4:0]            exp_wnum,
   output logic [31:0]           exp_wdata,
   output logic                  overflow,
   output logic                  done
);

   state_t                r_state;
   state_t                w_next_state;
   logic [CNT_W-1:0]      r_inst_cnt;
   logic [CNT_W-1:0]      r_cmp_cnt;
   logic [CNT_W-1:0]      r_err_cnt;
   logic                  r_err;
   logic                  r_overflow;
   logic                  r_done;
   commit_t               r_err_commit;
   commit_t               r_exp_commit;

   logic [LANES-1:0]      w_qual;
   commit_t [LANES-1:0]   w_lane_data;
   commit_t               w_head;
   logic                  w_empty;
   logic                  w_ovf;
   logic                  w_run;
   logic                  w_flush;
   logic                  w_pop;
   logic                  w_is_end;
   logic                  w_cmp;
   logic                  w_mismatch;
   logic [1:0]            w_err_inc;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [5:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, v} + {{(CNT_W-5){1'b0}}, inc};
      if (s[CNT_W]) begin
         return {CNT_W{1'b1}};
      end else begin
         return s[CNT_W-1:0];
      end
   endfunction

   // Unpack lanes; a lane qualifies when it writes a non-zero register outside the skip window.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_lane_data[i].pc    = wb_pc[32*i +: 32];
         w_lane_data[i].rd    = wb_rd[5*i +: 5];
         w_lane_data[i].wdata = wb_wdata[32*i +: 32];
         w_qual[i] = wb_en[i] && (wb_rd[5*i +: 5] != 5'd0) &&
                     ((wb_pc[32*i +: 32] & SKIP_MASK) != SKIP_BASE);
      end
   end

   wb_commit_fifo #(
      .LANES (LANES),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .resetn      (resetn),
      .i_flush     (w_flush),
      .i_push_en   (w_run),
      .i_lane_vld  (w_qual),
      .i_lane_data (w_lane_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_empty     (w_empty),
      .o_overflow  (w_ovf)
   );

   assign w_run      = (r_state == ST_RUN);
   assign w_flush    = w_run && !enable;
   assign ref_ready  = w_run && !w_empty;
   assign w_pop      = ref_valid && ref_ready;
   assign w_is_end   = (ref_pc == END_PC);
   assign w_cmp      = w_pop && !w_is_end;
   assign w_mismatch = w_cmp && ((w_head.pc != ref_pc) || (w_head.rd != ref_wnum) ||
                                 (w_head.wdata != ref_wdata));
   // A dropped group and a mismatch in the same cycle both count.
   assign w_err_inc  = {1'b0, w_ovf} + {1'b0, w_mismatch};

   // Next-state logic; DONE and HALT are left only through reset.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_pop && w_is_end) begin
               w_next_state = ST_DONE;
            end else if (w_mismatch && STOP_ON_ERR) begin
               w_next_state = ST_HALT;
            end else if (!enable) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         ST_DONE: w_next_state = ST_DONE;
         ST_HALT: w_next_state = ST_HALT;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Counters and sticky status; everything only moves while in RUN.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_inst_cnt   <= {CNT_W{1'b0}};
         r_cmp_cnt    <= {CNT_W{1'b0}};
         r_err_cnt    <= {CNT_W{1'b0}};
         r_err        <= 1'b0;
         r_overflow   <= 1'b0;
         r_done       <= 1'b0;
         r_err_commit <= '{pc: 32'd0, rd: 5'd0, wdata: 32'd0};
         r_exp_commit <= '{pc: 32'd0, rd: 5'd0, wdata: 32'd0};
      end else if (w_run) begin
         r_inst_cnt <= sat_add(r_inst_cnt, popcount(32'(wb_retire)));
         r_cmp_cnt  <= sat_add(r_cmp_cnt, {5'd0, w_cmp});
         r_err_cnt  <= sat_add(r_err_cnt, {4'd0, w_err_inc});
         if (w_ovf) begin
            r_overflow <= 1'b1;
         end
         if (w_pop && w_is_end) begin
            r_done <= 1'b1;
         end
         if (w_mismatch && !r_err) begin
            r_err        <= 1'b1;
            r_err_commit <= w_head;
            r_exp_commit <= '{pc: ref_pc, rd: ref_wnum, wdata: ref_wdata};
         end
      end
   end

   assign inst_cnt  = r_inst_cnt;
   assign cmp_cnt   = r_cmp_cnt;
   assign err_cnt   = r_err_cnt;
   assign err       = r_err;
   assign overflow  = r_overflow;
   assign done      = r_done;
   assign err_pc    = r_err_commit.pc;
   assign err_wnum  = r_err_commit.rd;
   assign err_wdata = r_err_commit.wdata;
   assign exp_pc    = r_exp_commit.pc;
   assign exp_wnum  = r_exp_commit.rd;
   assign exp_wdata = r_exp_commit.wdata;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Self-checking bench for wb_trace_checker (default parameters: 2 lanes,
// 8-entry FIFO, STOP_ON_ERR=1). A vector table covers matching, skip window,
// r0 filtering, packing, retire counting and END_PC; hand-written sequences
// cover mismatch/HALT, overflow with simultaneous pop, async reset and flush.
module tb_wb_trace_checker;

   logic          clk;
   logic          resetn;
   logic          enable;
   logic [1:0]    wb_en;
   logic [9:0]    wb_rd;
   logic [63:0]   wb_wdata;
   logic [63:0]   wb_pc;
   logic [1:0]    wb_retire;
   logic          ref_valid;
   logic          ref_ready;
   logic [31:0]   ref_pc;
   logic [4:0]    ref_wnum;
   logic [31:0]   ref_wdata;
   logic [31:0]   inst_cnt, cmp_cnt, err_cnt;
   logic          err, overflow, done;
   logic [31:0]   err_pc, err_wdata, exp_pc, exp_wdata;
   logic [4:0]    err_wnum, exp_wnum;

   int n_checks = 0;
   int n_errors = 0;

   wb_trace_checker dut (
      .clk(clk), .resetn(resetn), .enable(enable),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_pc(wb_pc), .wb_retire(wb_retire),
      .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc), .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
      .inst_cnt(inst_cnt), .cmp_cnt(cmp_cnt), .err_cnt(err_cnt), .err(err),
      .err_pc(err_pc), .err_wnum(err_wnum), .err_wdata(err_wdata),
      .exp_pc(exp_pc), .exp_wnum(exp_wnum), .exp_wdata(exp_wdata),
      .overflow(overflow), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  en;
      logic [31:0] pc0; logic [4:0] rd0; logic [31:0] d0;
      logic [31:0] pc1; logic [4:0] rd1; logic [31:0] d1;
      logic [1:0]  ret;
      logic        rv;
      logic [31:0] rpc; logic [4:0] rw; logic [31:0] rdat;
      logic        x_ready;
      int          x_inst;
      int          x_cmp;
      logic        x_done;
   } vec_t;

   vec_t vt [13];

   function automatic vec_t mv(logic [1:0] en, logic [31:0] pc0, logic [4:0] rd0, logic [31:0] d0,
                               logic [31:0] pc1, logic [4:0] rd1, logic [31:0] d1, logic [1:0] ret,
                               logic rv, logic [31:0] rpc, logic [4:0] rw, logic [31:0] rdat,
                               logic x_ready, int x_inst, int x_cmp, logic x_done);
      vec_t v;
      v.en = en; v.pc0 = pc0; v.rd0 = rd0; v.d0 = d0; v.pc1 = pc1; v.rd1 = rd1; v.d1 = d1;
      v.ret = ret; v.rv = rv; v.rpc = rpc; v.rw = rw; v.rdat = rdat;
      v.x_ready = x_ready; v.x_inst = x_inst; v.x_cmp = x_cmp; v.x_done = x_done;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then sample 1 time unit after the rising edge.
   task automatic cyc(input logic [1:0] en, input logic [31:0] pc0, input logic [4:0] rd0, input logic [31:0] d0,
                      input logic [31:0] pc1, input logic [4:0] rd1, input logic [31:0] d1, input logic [1:0] ret,
                      input logic rv, input logic [31:0] rpc, input logic [4:0] rw, input logic [31:0] rdat);
      @(negedge clk);
      wb_en = en; wb_pc = {pc1, pc0}; wb_rd = {rd1, rd0}; wb_wdata = {d1, d0}; wb_retire = ret;
      ref_valid = rv; ref_pc = rpc; ref_wnum = rw; ref_wdata = rdat;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(2'b00, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 2'b00, 1'b0, 32'd0, 5'd0, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0; enable = 1'b0;
      wb_en = 2'b00; wb_pc = 64'd0; wb_rd = 10'd0; wb_wdata = 64'd0; wb_retire = 2'b00;
      ref_valid = 1'b0; ref_pc = 32'd0; ref_wnum = 5'd0; ref_wdata = 32'd0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " inst_cnt"}, inst_cnt, 32'd0);
      chk({tag, " cmp_cnt"}, cmp_cnt, 32'd0);
      chk({tag, " err_cnt"}, err_cnt, 32'd0);
      chk({tag, " err"}, {31'd0, err}, 32'd0);
      chk({tag, " overflow"}, {31'd0, overflow}, 32'd0);
      chk({tag, " done"}, {31'd0, done}, 32'd0);
      chk({tag, " ref_ready"}, {31'd0, ref_ready}, 32'd0);
      chk({tag, " err_pc"}, err_pc, 32'd0);
      chk({tag, " err_wnum"}, {27'd0, err_wnum}, 32'd0);
      chk({tag, " err_wdata"}, err_wdata, 32'd0);
      chk({tag, " exp_pc"}, exp_pc, 32'd0);
      chk({tag, " exp_wnum"}, {27'd0, exp_wnum}, 32'd0);
      chk({tag, " exp_wdata"}, exp_wdata, 32'd0);
   endtask

   // Overflow-sequence commit k: pc, register and data derived from k.
   function automatic logic [31:0] e_pc(int k);
      return 32'hbfc01000 + 32'(4 * k);
   endfunction
   function automatic logic [4:0] e_rd(int k);
      return 5'(k + 1);
   endfunction
   function automatic logic [31:0] e_d(int k);
      return 32'(100 + k);
   endfunction

   initial begin
      //               en     pc0           rd0   d0      pc1           rd1    d1      ret    rv    rpc           rw     rdat    rdy   inst cmp done
      vt[0]  = mv(2'b00, 32'd0,        5'd0, 32'd0,  32'd0,        5'd0,  32'd0,  2'b00, 1'b0, 32'd0,        5'd0,  32'd0,  1'b0, 0, 0, 1'b0);
      vt[1]  = mv(2'b11, 32'hbfc00000, 5'd1, 32'd1,  32'hbfc00004, 5'd2,  32'd2,  2'b11, 1'b0, 32'd0,        5'd0,  32'd0,  1'b1, 2, 0, 1'b0);
      vt[2]  = mv(2'b00, 32'd0,        5'd0, 32'd0,  32'd0,        5'd0,  32'd0,  2'b00, 1'b1, 32'hbfc00000, 5'd1,  32'd1,  1'b1, 2, 1, 1'b0);
      vt[3]  = mv(2'b00, 32'd0,        5'd0, 32'd0,  32'd0,        5'd0,  32'd0,  2'b00, 1'b1, 32'hbfc00004, 5'd2,  32'd2,  1'b0, 2, 2, 1'b0);
      vt[4]  = mv(2'b11, 32'hbfc00384, 5'd5, 32'd55, 32'hbfc00020, 5'd0,  32'd66, 2'b11, 1'b0, 32'd0,        5'd0,  32'd0,  1'b0, 4, 2, 1'b0);
      vt[5]  = mv(2'b00, 32'd0,        5'd0, 32'd0,  32'd0,        5'd0,  32'd0,  2'b01, 1'b0, 32'd0,        5'd0,  32'd0,  1'b0, 5, 2, 1'b0);
      vt[6]  = mv(2'b11, 32'hbfc00387, 5'd4, 32'd7,  32'hbfc00388, 5'd6,  32'd8,  2'b11, 1'b0, 32'd0,        5'd0,  32'd0,  1'b1, 7, 2, 1'b0);
      vt[7]  = mv(2'b00, 32'd0,        5'd0, 32'd0,  32'd0,        5'd0,  32'd0,  2'b00, 1'b1, 32'hbfc00388, 5'd6,  32'd8,  1'b0, 7, 3, 1'b0);
      vt[8]  = mv(2'b10, 32'd0,        5'd0, 32'd0,  32'hbfc00030, 5'd7,  32'd9,  2'b10, 1'b1, 32'hbfc00030, 5'd7,  32'd9,  1'b1, 8, 3, 1'b0);
      vt[9]  = mv(2'b00, 32'd0,        5'd0, 32'd0,  32'd0,        5'd0,  32'd0,  2'b00, 1'b1, 32'hbfc00030, 5'd7,  32'd9,  1'b0, 8, 4, 1'b0);
      vt[10] = mv(2'b01, 32'hbfc00040, 5'd8, 32'd10, 32'd0,        5'd0,  32'd0,  2'b01, 1'b0, 32'd0,        5'd0,  32'd0,  1'b1, 9, 4, 1'b0);
      vt[11] = mv(2'b00, 32'd0,        5'd0, 32'd0,  32'd0,        5'd0,  32'd0,  2'b00, 1'b1, 32'hbfc00100, 5'd0,  32'd0,  1'b0, 9, 4, 1'b1);
      vt[12] = mv(2'b11, 32'hbfc00050, 5'd9, 32'd11, 32'hbfc00054, 5'd10, 32'd12, 2'b11, 1'b1, 32'hbfc00050, 5'd9,  32'd11, 1'b0, 9, 4, 1'b1);

      resetn = 1'b1;
      enable = 1'b0;
      #1;

      // Reset state
      do_reset();
      chk_all_zero("reset");

      // Table: match, lane order, skip window, r0, packing, retire count, END_PC
      enable = 1'b1;
      for (int i = 0; i < 13; i++) begin
         cyc(vt[i].en, vt[i].pc0, vt[i].rd0, vt[i].d0, vt[i].pc1, vt[i].rd1, vt[i].d1, vt[i].ret,
             vt[i].rv, vt[i].rpc, vt[i].rw, vt[i].rdat);
         chk($sformatf("vec%0d ref_ready", i), {31'd0, ref_ready}, {31'd0, vt[i].x_ready});
         chk($sformatf("vec%0d inst_cnt", i), inst_cnt, 32'(vt[i].x_inst));
         chk($sformatf("vec%0d cmp_cnt", i), cmp_cnt, 32'(vt[i].x_cmp));
         chk($sformatf("vec%0d done", i), {31'd0, done}, {31'd0, vt[i].x_done});
         chk($sformatf("vec%0d err_cnt", i), err_cnt, 32'd0);
         chk($sformatf("vec%0d err", i), {31'd0, err}, 32'd0);
      end

      // Mismatch with STOP_ON_ERR: first-error capture, then HALT
      do_reset();
      enable = 1'b1;
      idle();
      cyc(2'b01, 32'hbfc00010, 5'd3, 32'd5, 32'd0, 5'd0, 32'd0, 2'b01, 1'b0, 32'd0, 5'd0, 32'd0);
      cyc(2'b00, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 2'b00, 1'b1, 32'hbfc00010, 5'd3, 32'd6);
      chk("mm err", {31'd0, err}, 32'd1);
      chk("mm err_cnt", err_cnt, 32'd1);
      chk("mm cmp_cnt", cmp_cnt, 32'd1);
      chk("mm err_pc", err_pc, 32'hbfc00010);
      chk("mm err_wnum", {27'd0, err_wnum}, 32'd3);
      chk("mm err_wdata", err_wdata, 32'd5);
      chk("mm exp_pc", exp_pc, 32'hbfc00010);
      chk("mm exp_wnum", {27'd0, exp_wnum}, 32'd3);
      chk("mm exp_wdata", exp_wdata, 32'd6);
      chk("mm ref_ready", {31'd0, ref_ready}, 32'd0);
      cyc(2'b01, 32'hbfc00014, 5'd4, 32'd4, 32'd0, 5'd0, 32'd0, 2'b01, 1'b1, 32'hbfc00014, 5'd4, 32'd9);
      idle();
      chk("halt ref_ready", {31'd0, ref_ready}, 32'd0);
      chk("halt inst_cnt", inst_cnt, 32'd1);
      chk("halt cmp_cnt", cmp_cnt, 32'd1);
      chk("halt err_cnt", err_cnt, 32'd1);
      chk("halt err_wdata", err_wdata, 32'd5);

      // Overflow: four groups fill the FIFO, the fifth is dropped
      do_reset();
      enable = 1'b1;
      idle();
      for (int g = 0; g < 5; g++) begin
         cyc(2'b11, e_pc(2*g), e_rd(2*g), e_d(2*g), e_pc(2*g+1), e_rd(2*g+1), e_d(2*g+1), 2'b11,
             1'b0, 32'd0, 5'd0, 32'd0);
         if (g == 3) begin
            chk("ovf g3 overflow", {31'd0, overflow}, 32'd0);
            chk("ovf g3 err_cnt", err_cnt, 32'd0);
         end
      end
      chk("ovf overflow", {31'd0, overflow}, 32'd1);
      chk("ovf err_cnt", err_cnt, 32'd1);
      chk("ovf inst_cnt", inst_cnt, 32'd10);
      chk("ovf err", {31'd0, err}, 32'd0);
      // Full FIFO: pop plus one push fits because the post-pop count is used
      cyc(2'b01, e_pc(10), e_rd(10), e_d(10), 32'd0, 5'd0, 32'd0, 2'b00, 1'b1, e_pc(0), e_rd(0), e_d(0));
      chk("pushpop cmp_cnt", cmp_cnt, 32'd1);
      chk("pushpop err_cnt", err_cnt, 32'd1);
      cyc(2'b00, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 2'b00, 1'b1, e_pc(1), e_rd(1), e_d(1));
      cyc(2'b00, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 2'b00, 1'b1, e_pc(2), e_rd(2), e_d(2));
      chk("ovf drain cmp_cnt", cmp_cnt, 32'd3);
      chk("ovf drain err", {31'd0, err}, 32'd0);
      chk("ovf drain ref_ready", {31'd0, ref_ready}, 32'd1);

      // Asynchronous reset mid-run with a non-empty FIFO
      #2;
      resetn = 1'b0;
      enable = 1'b0;
      #1;
      chk_all_zero("async reset");
      @(negedge clk);
      resetn = 1'b1;
      idle();
      chk("post-reset idle ref_ready", {31'd0, ref_ready}, 32'd0);
      enable = 1'b1;
      idle();
      chk("post-reset run ref_ready", {31'd0, ref_ready}, 32'd0);

      // Dropping enable flushes the FIFO and holds the counters
      cyc(2'b01, 32'hbfc00060, 5'd12, 32'd77, 32'd0, 5'd0, 32'd0, 2'b01, 1'b0, 32'd0, 5'd0, 32'd0);
      chk("flush pre ref_ready", {31'd0, ref_ready}, 32'd1);
      enable = 1'b0;
      idle();
      chk("flush idle ref_ready", {31'd0, ref_ready}, 32'd0);
      chk("flush idle inst_cnt", inst_cnt, 32'd1);
      enable = 1'b1;
      idle();
      chk("flush rerun ref_ready", {31'd0, ref_ready}, 32'd0);
      chk("flush rerun inst_cnt", inst_cnt, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Synthesizable, parametrised writeback-trace checker for the N-issue core. Compares retired register writes against a golden trace streamed in over a valid/ready port.
- Sits beside the datapath, tapping the write-back channels. It takes the role the simulation-only trace judge held, so FPGA runs and non-SV simulators get the same check.
- Adds three things: commit buffering, in-order serialisation of N lanes, and retire counting. It also provides a PC skip window, stop-on-error, and sticky first-error capture.

Parameters:
- LANES, 2, write-back lanes; lane 0 is oldest.
- FIFO_DEPTH, 8, commit FIFO entries; power of 2, >= LANES.
- SKIP_BASE, 32'hbfc00380, skip-window base.
- SKIP_MASK, 32'hfffffff8, PC bits compared against SKIP_BASE.
- END_PC, 32'hbfc00100, PC whose commit ends checking.
- STOP_ON_ERR, 1, halt comparison at the first mismatch.
- CNT_W, 32, counter width.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  arms checker
- wb_en  in  LANES  lane write enable
- wb_rd  in  5*LANES  lane destination register
- wb_wdata  in  32*LANES  lane write data
- wb_pc  in  32*LANES  lane PC
- wb_retire  in  LANES  lane retired (counts even without a register write)
- ref_valid  in  1  golden entry valid
- ref_ready  out  1  golden entry consumed
- ref_pc  in  32  golden PC
- ref_wnum  in  5  golden register number
- ref_wdata  in  32  golden data
- inst_cnt  out  CNT_W  retired instructions
- cmp_cnt  out  CNT_W  comparisons performed
- err_cnt  out  CNT_W  mismatches
- err  out  1  sticky: at least one mismatch
- err_pc / err_wnum / err_wdata  out  32/5/32  first mismatching commit (DUT side)
- exp_pc / exp_wnum / exp_wdata  out  32/5/32  golden entry at the first mismatch
- overflow  out  1  sticky: commit FIFO overflow
- done  out  1  END_PC reached

Behaviour:
- Reset (async, resetn=0): every counter, err, overflow, done, and all err_*/exp_* outputs are 0. ref_ready=0. FIFO empty. State IDLE.
- States:
  - IDLE: ref_ready=0, nothing captured. Moves to RUN when enable=1.
  - RUN: capture and compare. Moves to DONE when END_PC is popped. Moves to HALT on a mismatch if STOP_ON_ERR=1. Returns to IDLE when enable=0; FIFO is flushed, counters are held.
  - DONE / HALT: terminal; ref_ready=0, no capture, counters frozen. Exit only via reset.
- Capture (RUN only), same cycle:
  - Qualifying lane i: wb_en[i] && wb_rd[i]!=0 && (wb_pc[i]&SKIP_MASK)!=SKIP_BASE.
  - Qualifying lanes are pushed in ascending lane order, packed contiguously.
  - If free slots < number of qualifying lanes, the whole cycle's group is dropped, overflow is set, and err_cnt increments by 1.
- inst_cnt increments by popcount(wb_retire) in RUN, independent of FIFO state.
- Compare (RUN):
  - ref_ready = FIFO non-empty. A pop happens when ref_valid && ref_ready: at most one per cycle, using registered FIFO output.
  - Golden entry with ref_pc==END_PC: consumed without comparison. Sets done next cycle and enters DONE.
  - Mismatch: any of pc/wnum/wdata differ. err_cnt+1. If err=0, latch err_*/exp_* and set err.
  - cmp_cnt increments on every non-END pop.
- Simultaneous push and pop in the same cycle is allowed. Occupancy = old + pushes − pop, and the full check uses the post-pop count.
- Latency: commit to compare result is at least 1 cycle. err and counters update on the edge after the pop.
- Counters saturate at all-ones; no wrap.
- Deasserting enable mid-stream flushes the FIFO; the golden stream is not rewound.

Decomposition:
- Package wb_trace_pkg:
  - typedef commit_t {pc[31:0], rd[4:0], wdata[31:0]}
  - state enum {IDLE, RUN, DONE, HALT}
  - function popcount.
- Sub-module wb_commit_fifo (LANES-write/1-read compaction FIFO, registered read, parametrised FIFO_DEPTH/LANES). The top level holds the FSM, comparator, and counters.

Test Plan:
- Dual-lane match: lane0 {bfc00000,r1,1}, lane1 {bfc00004,r2,2} in one cycle, golden identical → cmp_cnt=2, err=0, pops in lane order.
- Mismatch, STOP_ON_ERR=1: commit {bfc00010,r3,5}, golden {bfc00010,r3,6} → err=1, err_wdata=5, exp_wdata=6, state HALT, ref_ready=0 afterwards.
- Skip window and r0: commits at pc bfc00384 and rd=0 → not pushed, cmp_cnt unchanged; inst_cnt counts their wb_retire bits.
- Overflow: ref_valid=0, both lanes write every cycle for 5 cycles with FIFO_DEPTH=8 → 4 groups accepted; cycle 5 group dropped, overflow=1, err_cnt=1.
- END_PC: golden stream ends with pc bfc00100 → done=1 one cycle after the pop, counters frozen.
- Reset mid-run: resetn low during active compares with a non-empty FIFO → all outputs 0 immediately (async), FIFO empty, IDLE.
